// File: rtl/pong_pkg.sv
// Shared Pong definitions: game-state encodings, winner codes and screen geometry.
// Constants only; no latency and no flow control.
package pong_pkg;

  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_SERVE = 3'd1,
    ST_PLAY  = 3'd2,
    ST_PAUSE = 3'd3,
    ST_POINT = 3'd4,
    ST_OVER  = 3'd5
  } game_state_e;

  localparam logic [1:0] WIN_NONE = 2'b00;
  localparam logic [1:0] WIN_P1   = 2'b01;
  localparam logic [1:0] WIN_P2   = 2'b10;

  localparam int SCORE_W_DEF = 4;

  localparam int SCREEN_W      = 640;
  localparam int SCREEN_H      = 480;
  localparam int PADDLE_MARGIN = 15;
  localparam int P1_PADDLE_X   = PADDLE_MARGIN;
  localparam int P2_PADDLE_X   = SCREEN_W - PADDLE_MARGIN;

  // A ball that reaches a paddle's face without being returned is a miss.
  localparam int LEFT_MISS_X_DEF  = P1_PADDLE_X;
  localparam int RIGHT_MISS_X_DEF = P2_PADDLE_X;

  function automatic int max_int(input int a, input int b);
    return (a > b) ? a : b;
  endfunction

endpackage

// File: rtl/frame_countdown.sv
// Loadable frame down-counter; decrements on frame_tick, done is high while the count is zero.
// Load takes effect on the next edge and wins over a same-cycle tick; no backpressure.
module frame_countdown #(
  parameter int W = 6
) (
  input  logic         CLK_50,
  input  logic         reset_n,
  input  logic         load,
  input  logic [W-1:0] load_val,
  input  logic         tick,
  output logic         done
);

  logic [W-1:0] cnt;

  always_ff @(posedge CLK_50 or negedge reset_n) begin
    if (!reset_n) begin
      cnt <= '0;
    end else if (load) begin
      cnt <= load_val;
    end else if (tick && (cnt != '0)) begin
      cnt <= cnt - W'(1);
    end
  end

  assign done = (cnt == '0);

endmodule

// File: rtl/pong_game_ctrl.sv
// Pong match sequencer: serve countdown, play, pause, point freeze, game over, score keeping.
// All outputs registered, one CLK_50 edge after the qualifying input; pulses are never held off.
module pong_game_ctrl
  import pong_pkg::*;
#(
  parameter int WIN_SCORE    = 7,
  parameter int SERVE_FRAMES = 60,
  parameter int POINT_FRAMES = 90,
  parameter int LEFT_MISS_X  = LEFT_MISS_X_DEF,
  parameter int RIGHT_MISS_X = RIGHT_MISS_X_DEF,
  parameter int SCORE_W      = SCORE_W_DEF
) (
  input  logic               CLK_50,
  input  logic               reset_n,
  input  logic               frame_tick,
  input  logic               start_pulse,
  input  logic               pause_pulse,
  input  logic [9:0]         ball_x,
  output logic               ball_run,
  output logic               ball_reload,
  output logic               serve_dir,
  output logic [SCORE_W-1:0] score_p1,
  output logic [SCORE_W-1:0] score_p2,
  output logic [1:0]         winner,
  output logic [2:0]         game_state
);

  localparam int MAX_FRAMES = max_int(SERVE_FRAMES, POINT_FRAMES);
  localparam int CNT_W      = (MAX_FRAMES > 1) ? $clog2(MAX_FRAMES) : 1;

  localparam logic [CNT_W-1:0]   SERVE_LOAD = CNT_W'(SERVE_FRAMES - 1);
  localparam logic [CNT_W-1:0]   POINT_LOAD = CNT_W'(POINT_FRAMES - 1);
  localparam logic [9:0]         LEFT_X     = 10'(LEFT_MISS_X);
  localparam logic [9:0]         RIGHT_X    = 10'(RIGHT_MISS_X);
  localparam logic [SCORE_W-1:0] WIN_VAL    = SCORE_W'(WIN_SCORE);

  game_state_e      state_q;
  game_state_e      next_state;
  logic             cnt_load;
  logic [CNT_W-1:0] cnt_load_val;
  logic             cnt_done;
  logic             miss_left;
  logic             miss_right;
  logic             enter_serve;
  logic             match_start;

  frame_countdown #(.W(CNT_W)) u_countdown (
    .CLK_50   (CLK_50),
    .reset_n  (reset_n),
    .load     (cnt_load),
    .load_val (cnt_load_val),
    .tick     (frame_tick),
    .done     (cnt_done)
  );

  always_ff @(posedge CLK_50 or negedge reset_n) begin
    if (!reset_n) state_q <= ST_IDLE;
    else          state_q <= next_state;
  end

  always_comb begin
    next_state   = state_q;
    cnt_load     = 1'b0;
    cnt_load_val = '0;
    miss_left    = 1'b0;
    miss_right   = 1'b0;

    case (state_q)
      ST_IDLE: begin
        if (start_pulse) next_state = ST_SERVE;
      end
      ST_SERVE: begin
        if (frame_tick && cnt_done) next_state = ST_PLAY;
      end
      ST_PLAY: begin
        // A miss outranks a simultaneous pause request.
        if (ball_x <= LEFT_X) begin
          miss_left  = 1'b1;
          next_state = ST_POINT;
        end else if (ball_x >= RIGHT_X) begin
          miss_right = 1'b1;
          next_state = ST_POINT;
        end else if (pause_pulse) begin
          next_state = ST_PAUSE;
        end
      end
      ST_PAUSE: begin
        if (pause_pulse)      next_state = ST_PLAY;
        else if (start_pulse) next_state = ST_IDLE;
      end
      ST_POINT: begin
        if (frame_tick && cnt_done) begin
          if ((score_p1 == WIN_VAL) || (score_p2 == WIN_VAL)) next_state = ST_OVER;
          else                                                next_state = ST_SERVE;
        end
      end
      ST_OVER: begin
        if (start_pulse) next_state = ST_SERVE;
      end
      default: next_state = ST_IDLE;
    endcase

    if ((next_state == ST_SERVE) && (state_q != ST_SERVE)) begin
      cnt_load     = 1'b1;
      cnt_load_val = SERVE_LOAD;
    end else if ((next_state == ST_POINT) && (state_q != ST_POINT)) begin
      cnt_load     = 1'b1;
      cnt_load_val = POINT_LOAD;
    end
  end

  assign enter_serve = (next_state == ST_SERVE) && (state_q != ST_SERVE);
  assign match_start = enter_serve && ((state_q == ST_IDLE) || (state_q == ST_OVER));

  always_ff @(posedge CLK_50 or negedge reset_n) begin
    if (!reset_n) begin
      ball_run    <= 1'b0;
      ball_reload <= 1'b0;
      serve_dir   <= 1'b1;
      score_p1    <= '0;
      score_p2    <= '0;
      winner      <= WIN_NONE;
    end else begin
      ball_run    <= (next_state == ST_PLAY);
      ball_reload <= enter_serve;
      if (match_start) begin
        score_p1  <= '0;
        score_p2  <= '0;
        winner    <= WIN_NONE;
        serve_dir <= 1'b1;
      end
      // The next serve goes toward whoever conceded the point.
      if (miss_left) begin
        score_p2  <= score_p2 + SCORE_W'(1);
        serve_dir <= 1'b0;
      end else if (miss_right) begin
        score_p1  <= score_p1 + SCORE_W'(1);
        serve_dir <= 1'b1;
      end
      if ((state_q == ST_POINT) && (next_state == ST_OVER)) begin
        winner <= (score_p1 == WIN_VAL) ? WIN_P1 : WIN_P2;
      end
    end
  end

  assign game_state = state_q;

endmodule

// File: tb/tb_pong_game_ctrl.sv
// Bench for pong_game_ctrl: directed match scenarios plus random play against a game-rule model.
module tb_pong_game_ctrl;
  import pong_pkg::*;

  localparam int WIN = 7;
  localparam int SF  = 60;
  localparam int PF  = 90;
  localparam int LX  = 15;
  localparam int RX  = 625;
  localparam logic [9:0] MID = 10'd320;

  logic       CLK_50 = 1'b0;
  logic       reset_n = 1'b0;
  logic       frame_tick = 1'b0;
  logic       start_pulse = 1'b0;
  logic       pause_pulse = 1'b0;
  logic [9:0] ball_x = MID;
  logic       ball_run, ball_reload, serve_dir;
  logic [3:0] score_p1, score_p2;
  logic [1:0] winner;
  logic [2:0] game_state;

  int tests = 0;
  int fails = 0;
  bit chk_en = 1'b0;
  bit force_bad = 1'b0;

  // Game-rule model: mode name as int 0..5, ticks still needed before leaving a timed phase.
  int m_mode = 0, m_left = 0, m_p1 = 0, m_p2 = 0, m_win = 0;
  bit m_dir = 1'b1, m_run = 1'b0, m_rel = 1'b0;

  pong_game_ctrl dut (
    .CLK_50      (CLK_50),
    .reset_n     (reset_n),
    .frame_tick  (frame_tick),
    .start_pulse (start_pulse),
    .pause_pulse (pause_pulse),
    .ball_x      (ball_x),
    .ball_run    (ball_run),
    .ball_reload (ball_reload),
    .serve_dir   (serve_dir),
    .score_p1    (score_p1),
    .score_p2    (score_p2),
    .winner      (winner),
    .game_state  (game_state)
  );

  always #10 CLK_50 = ~CLK_50;

  task automatic chk(input string name, input int act, input int exp);
    tests++;
    if (act != exp) begin
      fails++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  initial begin
    forever begin
      @(posedge CLK_50 or negedge reset_n);
      if (!reset_n) begin
        m_mode = 0; m_left = 0; m_p1 = 0; m_p2 = 0; m_win = 0;
        m_dir = 1'b1; m_run = 1'b0; m_rel = 1'b0;
      end else begin
        bit go_serve;
        go_serve = 1'b0;
        m_rel = 1'b0;
        if (force_bad) begin
          m_mode = 0;
          force_bad = 1'b0;
        end else begin
          case (m_mode)
            0: if (start_pulse) begin
                 m_p1 = 0; m_p2 = 0; m_win = 0; m_dir = 1'b1; go_serve = 1'b1;
               end
            1: if (frame_tick) begin
                 m_left--;
                 if (m_left == 0) m_mode = 2;
               end
            2: if (int'(ball_x) <= LX) begin
                 m_p2++; m_dir = 1'b0; m_mode = 4; m_left = PF;
               end else if (int'(ball_x) >= RX) begin
                 m_p1++; m_dir = 1'b1; m_mode = 4; m_left = PF;
               end else if (pause_pulse) begin
                 m_mode = 3;
               end
            3: if (pause_pulse) m_mode = 2;
               else if (start_pulse) m_mode = 0;
            4: if (frame_tick) begin
                 m_left--;
                 if (m_left == 0) begin
                   if (m_p1 == WIN || m_p2 == WIN) begin
                     m_mode = 5;
                     m_win = (m_p1 == WIN) ? 1 : 2;
                   end else begin
                     go_serve = 1'b1;
                   end
                 end
               end
            5: if (start_pulse) begin
                 m_p1 = 0; m_p2 = 0; m_win = 0; m_dir = 1'b1; go_serve = 1'b1;
               end
            default: m_mode = 0;
          endcase
        end
        if (go_serve) begin
          m_mode = 1; m_left = SF; m_rel = 1'b1;
        end
        m_run = (m_mode == 2);
      end
    end
  end

  always @(negedge CLK_50) begin
    if (chk_en) begin
      chk("state", int'(game_state), m_mode);
      chk("ball_run", int'(ball_run), int'(m_run));
      chk("ball_reload", int'(ball_reload), int'(m_rel));
      chk("serve_dir", int'(serve_dir), int'(m_dir));
      chk("score_p1", int'(score_p1), m_p1);
      chk("score_p2", int'(score_p2), m_p2);
      chk("winner", int'(winner), m_win);
    end
  end

  // Drive one cycle of inputs from a negedge; returns at the following negedge.
  task automatic cyc(input bit ft, input bit st, input bit ps, input logic [9:0] bx);
    frame_tick = ft; start_pulse = st; pause_pulse = ps; ball_x = bx;
    @(negedge CLK_50);
    frame_tick = 1'b0; start_pulse = 1'b0; pause_pulse = 1'b0;
  endtask

  task automatic ticks(input int n, input logic [9:0] bx);
    for (int i = 0; i < n; i++) begin
      cyc(1'b0, 1'b0, 1'b0, bx);
      cyc(1'b1, 1'b0, 1'b0, bx);
    end
  endtask

  task automatic async_reset_pulse();
    #3 reset_n = 1'b0;
    @(negedge CLK_50);
    reset_n = 1'b1;
  endtask

  initial begin
    chk_en = 1'b1;
    repeat (3) @(negedge CLK_50);
    chk("rst_state", int'(game_state), 0);
    chk("rst_dir", int'(serve_dir), 1);
    chk("rst_run", int'(ball_run), 0);
    reset_n = 1'b1;
    cyc(1'b1, 1'b0, 1'b1, MID);
    chk("idle_hold", int'(game_state), 0);

    // Start, with a frame tick on the entry cycle that must be ignored.
    cyc(1'b1, 1'b1, 1'b0, MID);
    chk("start_reload", int'(ball_reload), 1);
    chk("start_state", int'(game_state), 1);
    cyc(1'b0, 1'b0, 1'b0, MID);
    chk("reload_1cyc", int'(ball_reload), 0);
    ticks(SF - 1, MID);
    chk("serve_59", int'(game_state), 1);
    ticks(1, MID);
    chk("serve_60_state", int'(game_state), 2);
    chk("serve_60_run", int'(ball_run), 1);

    // Left miss; ball stays out during the freeze and must not rescore.
    cyc(1'b0, 1'b0, 1'b0, 10'd10);
    chk("lmiss_p2", int'(score_p2), 1);
    chk("lmiss_dir", int'(serve_dir), 0);
    chk("lmiss_run", int'(ball_run), 0);
    chk("lmiss_state", int'(game_state), 4);
    ticks(PF, 10'd10);
    chk("point_exp_state", int'(game_state), 1);
    chk("point_exp_reload", int'(ball_reload), 1);
    chk("point_no_double", int'(score_p2), 1);
    ticks(SF, MID);

    // Pause freezes everything; a miss outranks a pause.
    cyc(1'b0, 1'b1, 1'b1, MID);
    chk("pause_state", int'(game_state), 3);
    chk("pause_run", int'(ball_run), 0);
    ticks(200, MID);
    chk("pause_hold", int'(game_state), 3);
    cyc(1'b0, 1'b0, 1'b1, MID);
    chk("unpause_state", int'(game_state), 2);
    cyc(1'b0, 1'b0, 1'b1, 10'd630);
    chk("rmiss_p1", int'(score_p1), 1);
    chk("rmiss_state", int'(game_state), 4);

    for (int k = 2; k <= WIN; k++) begin
      ticks(PF, 10'd630);
      chk("p1_hold", int'(score_p1), k - 1);
      ticks(SF, MID);
      cyc(1'b0, 1'b0, 1'b0, 10'd630);
      chk("p1_score", int'(score_p1), k);
    end
    ticks(PF, 10'd630);
    chk("over_state", int'(game_state), 5);
    chk("over_winner", int'(winner), 1);
    repeat (5) cyc(1'b1, 1'b0, 1'b0, 10'd630);
    chk("over_p1_hold", int'(score_p1), 7);
    cyc(1'b0, 1'b1, 1'b0, MID);
    chk("restart_p1", int'(score_p1), 0);
    chk("restart_p2", int'(score_p2), 0);
    chk("restart_winner", int'(winner), 0);
    chk("restart_state", int'(game_state), 1);

    // Async reset mid-countdown: outputs must clear before any clock edge.
    ticks(29, MID);
    #3 reset_n = 1'b0;
    #1;
    chk("arst_state", int'(game_state), 0);
    chk("arst_reload", int'(ball_reload), 0);
    chk("arst_dir", int'(serve_dir), 1);
    @(negedge CLK_50);
    reset_n = 1'b1;
    ticks(40, MID);
    cyc(1'b0, 1'b0, 1'b1, MID);
    chk("post_rst_idle", int'(game_state), 0);

    // Illegal encoding recovers to IDLE.
    cyc(1'b0, 1'b1, 1'b0, MID);
    ticks(SF, MID);
    #2 force dut.state_q = game_state_e'(3'd6);
    force_bad = 1'b1;
    #2 release dut.state_q;
    @(negedge CLK_50);
    chk("bad_enc_state", int'(game_state), 0);
    chk("bad_enc_run", int'(ball_run), 0);

    // Random play.
    for (int i = 0; i < 15000; i++) begin
      int r;
      logic [9:0] bx;
      r = $urandom_range(0, 99);
      if (r < 3)      bx = 10'($urandom_range(0, LX));
      else if (r < 6) bx = 10'($urandom_range(RX, 1023));
      else            bx = 10'($urandom_range(LX + 1, RX - 1));
      if (i % 4000 == 2345) async_reset_pulse();
      cyc(1'($urandom_range(0, 1)), ($urandom_range(0, 999) < 4),
          ($urandom_range(0, 999) < 8), bx);
    end

    chk_en = 1'b0;
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

// File: doc/pong_game_ctrl.md
Name: pong_game_ctrl

Overview:
- Game-sequencing controller for the Pong datapath. Runs the match lifecycle: attract/idle, serve countdown, live play, point freeze, pause and game over.
- Gates and re-centres the ball-motion engine and keeps both players' scores.
- Sits beside the ball-motion and paddle blocks in the top level. It consumes the ball position and a once-per-frame tick, and drives the ball enable/reload controls plus score and winner signals to the renderer.

Parameters:
- WIN_SCORE, 7, points needed to win; legal range 1..(2^SCORE_W)-1
- SERVE_FRAMES, 60, frames the ball sits centred before launch; must be >=1
- POINT_FRAMES, 90, frames of freeze after a point; must be >=1
- LEFT_MISS_X, 15, ball_x at or below this value is a miss by P1
- RIGHT_MISS_X, 625, ball_x at or above this value is a miss by P2; must exceed LEFT_MISS_X
- SCORE_W, 4, score counter width

Ports:
- CLK_50  in  1  system clock, 50 MHz
- reset_n  in  1  asynchronous active-low reset
- frame_tick  in  1  one-cycle pulse per video frame (start of vertical blank), CLK_50 domain
- start_pulse  in  1  one-cycle debounced button-edge pulse; starts or restarts a match
- pause_pulse  in  1  one-cycle debounced button-edge pulse; toggles pause
- ball_x  in  10  current ball X pixel position
- ball_run  out  1  ball motion enable
- ball_reload  out  1  one-cycle pulse; ball engine re-centres and takes serve_dir
- serve_dir  out  1  0 = launch toward P1 (left), 1 = launch toward P2 (right)
- score_p1  out  SCORE_W  P1 points
- score_p2  out  SCORE_W  P2 points
- winner  out  2  00 none, 01 P1, 10 P2
- game_state  out  3  encoded FSM state for on-screen status text

Behaviour:
- Reset (async assert, sync release):
  - state IDLE; ball_run=0, ball_reload=0, serve_dir=1
  - scores 0, winner 00, frame counter 0
- All outputs are registered. Transitions take effect on the CLK_50 edge after the qualifying input.
- States, with encoding: IDLE=0, SERVE=1, PLAY=2, PAUSE=3, POINT=4, OVER=5.
- IDLE:
  - ball_run=0
  - on start_pulse: go to SERVE, clear both scores and winner, serve_dir=1.
- SERVE entry (every entry path):
  - ball_reload=1 for exactly one cycle
  - frame counter loaded with SERVE_FRAMES-1; ball_run=0
  - each frame_tick decrements the counter; a frame_tick while the counter is 0 goes to PLAY
  - a frame_tick on the entry cycle itself is ignored (the counter load wins)
- PLAY:
  - ball_run=1
  - ball_x<=LEFT_MISS_X: score_p2 increments and serve_dir=0 (serve toward the conceding P1). ball_x>=RIGHT_MISS_X: score_p1 increments and serve_dir=1.
  - either miss goes to POINT; the left check has priority (the two cannot coexist when parameters are legal)
  - pause_pulse with no miss goes to PAUSE; a miss and pause_pulse in the same cycle resolve as the miss
  - start_pulse is ignored
- PAUSE:
  - ball_run=0; frame_tick is ignored
  - pause_pulse returns to PLAY; start_pulse returns to IDLE
- POINT:
  - ball_run=0; counter loaded with POINT_FRAMES-1 on entry and counted as in SERVE
  - on expiry: either score==WIN_SCORE goes to OVER, otherwise SERVE
  - only one score changes per point; miss detection is inactive outside PLAY, so a ball still beyond a threshold cannot double-score
- OVER:
  - ball_run=0; winner=01 if score_p1==WIN_SCORE, else 10
  - scores hold for display; start_pulse goes to SERVE with scores cleared and winner=00
- Score increments never wrap: the counter cannot exceed WIN_SCORE because OVER is entered first.
- Undefined encodings 6 and 7 recover to IDLE on the next edge.
- Asynchronous reset at any point, including mid-countdown, forces the reset values immediately. No pulse is replayed after release.

Decomposition:
- Shared package pong_pkg holds:
  - the game-state enumeration and its 3-bit encodings
  - winner codes
  - the SCORE_W default
  - screen constants (640, 480, paddle X positions) from which LEFT_MISS_X and RIGHT_MISS_X defaults derive
- One natural sub-module: frame_countdown, a loadable down-counter decremented by frame_tick that raises a done flag at zero. It is instantiated once and shared between SERVE and POINT.

Test Plan:
- Reset, then start_pulse -> ball_reload high for 1 cycle; game_state=1; after exactly 60 frame_ticks, ball_run=1 and game_state=2.
- In PLAY drive ball_x=10 -> next edge: score_p2=1, serve_dir=0, ball_run=0, state=4; after 90 ticks, state=1 with a fresh ball_reload.
- In PLAY assert pause_pulse -> state=3, ball_run=0, 200 frame_ticks cause no change; second pause_pulse -> state=2. pause_pulse and ball_x=630 in the same cycle -> score_p1 increments, state=4.
- Drive P1 to 7 points via ball_x=630 -> after the final POINT expiry, state=5, winner=01; holding ball_x=630 adds no further score; start_pulse -> scores 0, winner 00, state=1.
- Assert reset_n low mid-SERVE at counter=30 -> outputs take reset values without a clock edge; after release, state stays 0 until start_pulse.
- Force state 6 via a bench hook -> state=0 on the next edge.
